// File: rtl/alu_issue_unit.sv
// alu_issue_unit
// Issue/writeback sequencer that sits in front of sixteen_bit_alu and owns an
// 8 x 16-bit register file (r0 is hard-wired to zero on every read path).
// One instruction is handled at a time through IDLE -> READ -> EXEC -> WB.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   instr_valid/ready   instruction handshake (ready only while IDLE)
//   instr[15:0]         op[15:12] rd[11:9] rs[8:6] rt[5:3] imm9[8:0]
//   alu_a/alu_b/alu_op  registered operands and opcode driven to the ALU
//   alu_out             combinational result returned by the ALU
//   res_valid           one-cycle writeback pulse
//   res_data/res_rd     last written value and its destination (held)
//   flag_z/flag_n       zero / negative of res_data, updated with res_valid
//   err                 one-cycle pulse when an illegal op retires
//   dbg_addr/dbg_data   combinational debug read port of the register file
module alu_issue_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [15:0] alu_out,
    output logic        res_valid,
    output logic [15:0] res_data,
    output logic [2:0]  res_rd,
    output logic        flag_z,
    output logic        flag_n,
    output logic        err,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    localparam logic [3:0] OP_LDI = 4'b0111;

    state_t      state;
    state_t      state_next;
    logic [15:0] ir;
    logic [15:0] wb_reg;
    logic [15:0] regs [8];

    logic [3:0]  ir_op;
    logic [2:0]  ir_rd;
    logic [2:0]  ir_rs;
    logic [2:0]  ir_rt;
    logic [8:0]  ir_imm;
    logic        ir_illegal;
    logic [15:0] rs_val;
    logic [15:0] rt_val;

    assign ir_op  = ir[15:12];
    assign ir_rd  = ir[11:9];
    assign ir_rs  = ir[8:6];
    assign ir_rt  = ir[5:3];
    assign ir_imm = ir[8:0];

    // Holes in the opcode map; these retire with err instead of a writeback.
    assign ir_illegal = (ir_op == 4'b1011) || (ir_op == 4'b1101) || (ir_op == 4'b1111);

    // r0 reads as zero everywhere, independent of what the array holds.
    assign rs_val   = (ir_rs == 3'd0)    ? 16'h0000 : regs[ir_rs];
    assign rt_val   = (ir_rt == 3'd0)    ? 16'h0000 : regs[ir_rt];
    assign dbg_data = (dbg_addr == 3'd0) ? 16'h0000 : regs[dbg_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fixed four-step sequence; only IDLE waits on the handshake.
    // Ready is masked by rst so nothing appears accepted during reset.
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = ~rst;
                if (instr_valid) begin
                    state_next = READ;
                end
            end
            READ:    state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Register file: written only in WB for legal ops, never at r0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 16'h0000;
            end
        end else if (state == WB && !ir_illegal && ir_rd != 3'd0) begin
            regs[ir_rd] <= wb_reg;
        end
    end

    // Datapath: latch instruction, present operands, capture the result,
    // then publish it. res_valid and err default low so each is a pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir        <= 16'h0000;
            alu_a     <= 16'h0000;
            alu_b     <= 16'h0000;
            alu_op    <= 4'h0;
            wb_reg    <= 16'h0000;
            res_valid <= 1'b0;
            res_data  <= 16'h0000;
            res_rd    <= 3'd0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            err       <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir <= instr;
                    end
                end
                READ: begin
                    alu_a  <= rs_val;
                    alu_b  <= rt_val;
                    alu_op <= ir_op;
                end
                EXEC: begin
                    if (ir_op == OP_LDI) begin
                        wb_reg <= {{7{ir_imm[8]}}, ir_imm};
                    end else if (!ir_illegal) begin
                        wb_reg <= alu_out;
                    end
                end
                WB: begin
                    if (ir_illegal) begin
                        err <= 1'b1;
                    end else begin
                        res_valid <= 1'b1;
                        res_data  <= wb_reg;
                        res_rd    <= ir_rd;
                        flag_z    <= (wb_reg == 16'h0000);
                        flag_n    <= wb_reg[15];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
